cpu_trace_emitter: RTL and testbench
====================================

Name: cpu_trace_emitter

Overview:
Serializes one CPU write-back event per request into the ASCII trace stream consumed by cpu_checker, one character per accepted transfer. Register-write frame: "^<time>@<pc>: $<grf> <= <data>#". Memory-write frame: "^<time>@<pc>: *<addr> <= <data>#". Sits between the CPU model and cpu_checker / trace sinks, and gives the checker bench a bit-exact, legal-format stimulus source.

Parameters:
TIME_MAX, 9999, saturation ceiling for decimal time; must fit 4 decimal digits.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; transfer when req_valid && req_ready at a rising edge
req_is_mem  input  1  0 = register frame ($grf), 1 = memory frame (*addr)
req_time  input  14  binary time stamp
req_pc  input  32  PC
req_grf  input  5  register number, 0..31
req_addr  input  32  memory address (ignored when req_is_mem=0)
req_data  input  32  write data
char  output  8  current ASCII character
char_valid  output  1  char is valid
char_ready  input  1  sink accepts char when char_valid && char_ready at a rising edge
busy  output  1  high in CONV or EMIT
frame_done  output  1  one-cycle pulse in the cycle after '#' is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, char=8'h00, char_valid=0, busy=0, frame_done=0, req_ready=1. Deassertion is sampled on the next rising edge. Any frame in progress is dropped and no further characters from it are emitted.
- States: IDLE -> CONV -> EMIT -> IDLE.
- IDLE: on accept, register all request fields. Saturate time to min(req_time, TIME_MAX). Go to CONV.
- CONV: sequential double-dabble conversion, one bit per cycle. It converts the 14-bit time to 4 BCD digits and the 5-bit grf to 2 BCD digits in parallel. Exactly 14 cycles. char_valid=0 throughout.
- EMIT: char_valid rises on the edge ending CONV, so the first '^' is visible 15 cycles after the accept edge. A field/index counter walks the frame.
  - char is held stable while char_valid && !char_ready.
  - One character advances per accepted transfer, with no bubbles.
- Decimal fields (time, grf) suppress leading zeros; a value of 0 emits a single "0".
- Hex fields (pc, addr, data) are always 8 digits, MSB first, lowercase a-f.
- Separators are exact: one space after ':', one space on each side of "<=", and no other spaces.
- Frame length:
  - Register frame: 26 + Dt + Dg characters.
  - Memory frame: 34 + Dt characters.
  - Dt and Dg are the digit counts of time and grf.
- When '#' is accepted: go to IDLE, char_valid=0, pulse frame_done for 1 cycle. req_ready=1 in that same cycle, so back-to-back frames are allowed (next accept is possible in the frame_done cycle).
- req_* inputs are ignored outside IDLE. Fields are latched and immune to later input changes.
- char holds its last value when char_valid=0. The bench must not check it then.

Test Plan:
- Register frame, no stall: time=5, pc=0x00003000, grf=0, data=0x00000001, char_ready=1 -> exactly "^5@00003000: $0 <= 00000001#" (28 chars on 28 consecutive cycles); frame_done 1 cycle after '#'.
- Memory frame: time=338, pc=0x00003130, addr=0x00000088, data=0xffffb528 -> "^338@00003130: *00000088 <= ffffb528#" (37 chars). Feeding this into cpu_checker gives format_type=2 after '#'.
- Backpressure: same memory frame with char_ready toggling 1,0,0,1,... -> identical 37-char sequence, char stable during every stall cycle, no drops or duplicates.
- Saturation and two-digit grf: time=12000, grf=31 -> frame begins "^9999@", contains "$31 <=". Time=0 -> "^0@".
- Reset mid-frame: pull reset low after the 10th accepted char -> char_valid=0 and req_ready=1 immediately. After release, a new request emits a complete fresh frame starting '^'.
- Back-to-back: assert a second request in the frame_done cycle -> accepted on that edge, its '^' appears 15 cycles later. req_ready=0 and busy=1 in between.

Source files
------------

// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back event into an ASCII trace frame, one character
// per valid/ready transfer: "^<time>@<pc>: $<grf> <= <data>#" or "... *<addr> ...".
module cpu_trace_emitter #(
  parameter int TIME_MAX = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_mem,
  input  logic [13:0] req_time,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_grf,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [7:0]  char,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  localparam logic [13:0] TIME_SAT = 14'(TIME_MAX);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [5:0]  pos_reg;
  logic        is_mem_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [13:0] t_bin_reg;
  logic [15:0] t_bcd_reg;
  logic [4:0]  g_bin_reg;
  logic [7:0]  g_bcd_reg;
  logic [7:0]  char_reg;
  logic        char_valid_reg;
  logic        frame_done_reg;

  logic [15:0] t_adj;
  logic [7:0]  g_adj;
  logic [2:0]  dt;
  logic [1:0]  dg;
  logic [5:0]  last_pos;
  logic [5:0]  p;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [1:0]  t_idx;
  logic [7:0]  char_next;

  // Double-dabble "add 3" correction on every BCD digit before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tadj
      assign t_adj[gi*4 +: 4] = (t_bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                t_bcd_reg[gi*4 +: 4] + 4'd3 : t_bcd_reg[gi*4 +: 4];
    end
    for (gi = 0; gi < 2; gi++) begin : g_gadj
      assign g_adj[gi*4 +: 4] = (g_bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                g_bcd_reg[gi*4 +: 4] + 4'd3 : g_bcd_reg[gi*4 +: 4];
    end
  endgenerate

  function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] i);
    logic [3:0] n;
    n = 4'(w >> {3'd7 - i, 2'b00});
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h57 + {4'd0, n};
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'd0, n};
  endfunction

  assign dt = (t_bcd_reg[15:12] != 4'd0) ? 3'd4 :
              (t_bcd_reg[11:8]  != 4'd0) ? 3'd3 :
              (t_bcd_reg[7:4]   != 4'd0) ? 3'd2 : 3'd1;
  assign dg = (g_bcd_reg[7:4] != 4'd0) ? 2'd2 : 2'd1;
  assign last_pos = is_mem_reg ? 6'd33 + {3'd0, dt} : 6'd25 + {3'd0, dt} + {4'd0, dg};

  // Character for the next frame position; a marks '@', b marks the space before "<=".
  always_comb begin
    p         = pos_reg + 6'd1;
    a         = 6'd1 + {3'd0, dt};
    b         = is_mem_reg ? a + 6'd20 : a + 6'd12 + {4'd0, dg};
    t_idx     = 2'(dt - p[2:0]);
    char_next = 8'h23;
    if (p <= {3'd0, dt})         char_next = dec_char(4'(t_bcd_reg >> {t_idx, 2'b00}));
    else if (p == a)             char_next = "@";
    else if (p <= a + 6'd8)      char_next = hex_char(pc_reg, 3'(p - a - 6'd1));
    else if (p == a + 6'd9)      char_next = ":";
    else if (p == a + 6'd10)     char_next = " ";
    else if (p == a + 6'd11)     char_next = is_mem_reg ? "*" : "$";
    else if (p < b) begin
      if (is_mem_reg)            char_next = hex_char(addr_reg, 3'(p - a - 6'd12));
      else                       char_next = dec_char((dg == 2'd2 && p == a + 6'd12) ?
                                                      g_bcd_reg[7:4] : g_bcd_reg[3:0]);
    end
    else if (p == b)             char_next = " ";
    else if (p == b + 6'd1)      char_next = "<";
    else if (p == b + 6'd2)      char_next = "=";
    else if (p == b + 6'd3)      char_next = " ";
    else if (p <= b + 6'd11)     char_next = hex_char(data_reg, 3'(p - b - 6'd4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      pos_reg        <= 6'd0;
      is_mem_reg     <= 1'b0;
      pc_reg         <= 32'd0;
      addr_reg       <= 32'd0;
      data_reg       <= 32'd0;
      t_bin_reg      <= 14'd0;
      t_bcd_reg      <= 16'd0;
      g_bin_reg      <= 5'd0;
      g_bcd_reg      <= 8'd0;
      char_reg       <= 8'h00;
      char_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (req_valid) begin
          is_mem_reg <= req_is_mem;
          pc_reg     <= req_pc;
          addr_reg   <= req_addr;
          data_reg   <= req_data;
          t_bin_reg  <= (req_time > TIME_SAT) ? TIME_SAT : req_time;
          t_bcd_reg  <= 16'd0;
          g_bin_reg  <= req_grf;
          g_bcd_reg  <= 8'd0;
          cnt_reg    <= 4'd0;
          state_reg  <= CONV;
        end
        CONV: begin
          {t_bcd_reg, t_bin_reg} <= {t_adj, t_bin_reg} << 1;
          // grf needs only 5 shifts; run them in the last 5 of the 14 cycles.
          if (cnt_reg >= 4'd9) {g_bcd_reg, g_bin_reg} <= {g_adj, g_bin_reg} << 1;
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'd13) begin
            state_reg      <= EMIT;
            pos_reg        <= 6'd0;
            char_reg       <= "^";
            char_valid_reg <= 1'b1;
          end
        end
        EMIT: if (char_ready) begin
          if (pos_reg == last_pos) begin
            state_reg      <= IDLE;
            char_valid_reg <= 1'b0;
            frame_done_reg <= 1'b1;
          end else begin
            pos_reg  <= pos_reg + 6'd1;
            char_reg <= char_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign char       = char_reg;
  assign char_valid = char_valid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: directed frame table, reset-abort sequence and
// randomized frames compared against a string-formatting reference model.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_mem;
  logic [13:0] req_time;
  logic [31:0] req_pc;
  logic [4:0]  req_grf;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_mem(req_is_mem), .req_time(req_time), .req_pc(req_pc), .req_grf(req_grf),
    .req_addr(req_addr), .req_data(req_data), .char(char), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    bit          m;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  g;
    logic [31:0] ad;
    logic [31:0] d;
    int          mode;
  } vec_t;

  localparam int NV = 7;
  vec_t  vt[NV];
  string et[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=\"%s\" want=\"%s\"", name, got, exp);
    end
  endtask

  function automatic string model(input bit m, input logic [13:0] t, input logic [31:0] pc,
                                  input logic [4:0] g, input logic [31:0] ad, input logic [31:0] d);
    int ts;
    ts = (int'(t) > 9999) ? 9999 : int'(t);
    if (m) return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, ad, d);
    return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, g, d);
  endfunction

  // Called at a negedge; returns just after the accepting edge with inputs scrambled.
  task automatic send(input bit m, input logic [13:0] t, input logic [31:0] pc,
                      input logic [4:0] g, input logic [31:0] ad, input logic [31:0] d);
    int w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", req_ready, 1);
    req_valid = 1; req_is_mem = m; req_time = t; req_pc = pc;
    req_grf = g; req_addr = ad; req_data = d;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_is_mem = 1'($urandom); req_time = 14'($urandom); req_pc = $urandom;
    req_grf = 5'($urandom); req_addr = $urandom; req_data = $urandom;
  endtask

  // Collects characters; mode 0 always ready, 1 ready every third cycle, 2 random.
  task automatic run_frame(input string name, input string exp, input int mode,
                           input int max_chars, output string got);
    int   cyc = 0, first = 0, pre_bad = 0, stall_bad = 0, bubbles = 0;
    logic pstall = 0;
    logic [7:0] pch = 0;
    bit   done = 0;
    got = "";
    while (!done && got.len() < max_chars && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (char_valid && first == 0) first = cyc;
      if (first == 0 && (req_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0)) pre_bad++;
      if (pstall && (char_valid !== 1'b1 || char !== pch)) stall_bad++;
      if (first != 0 && char_valid !== 1'b1) bubbles++;
      case (mode)
        0:       char_ready = 1'b1;
        1:       char_ready = (cyc % 3 == 0);
        default: char_ready = 1'($urandom);
      endcase
      pstall = char_valid && !char_ready;
      pch    = char;
      if (char_valid && char_ready) begin
        got = $sformatf("%s%c", got, char);
        if (char == 8'h23) done = 1;
      end
    end
    $display("frame %s: mode=%0d latency=%0d \"%s\"", name, mode, first, got);
    if (max_chars < 1000) return;
    chk_str({name, "_text"}, got, exp);
    chk({name, "_latency"}, first, 15);
    chk({name, "_conv_flags"}, pre_bad, 0);
    chk({name, "_stall_hold"}, stall_bad, 0);
    chk({name, "_bubbles"}, bubbles, 0);
    @(negedge clk);
    chk({name, "_frame_done"}, frame_done, 1);
    chk({name, "_valid_low"}, char_valid, 0);
    chk({name, "_ready_back"}, req_ready, 1);
    chk({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    string got, exp;
    vt[0] = '{0, 14'd5,     32'h00003000, 5'd0,  32'h0,        32'h00000001, 0};
    et[0] = "^5@00003000: $0 <= 00000001#";
    vt[1] = '{1, 14'd338,   32'h00003130, 5'd0,  32'h00000088, 32'hffffb528, 0};
    et[1] = "^338@00003130: *00000088 <= ffffb528#";
    vt[2] = '{1, 14'd338,   32'h00003130, 5'd3,  32'h00000088, 32'hffffb528, 1};
    et[2] = "^338@00003130: *00000088 <= ffffb528#";
    vt[3] = '{0, 14'd12000, 32'hdeadbeef, 5'd31, 32'h0,        32'h0badf00d, 2};
    et[3] = "^9999@deadbeef: $31 <= 0badf00d#";
    vt[4] = '{0, 14'd0,     32'h00000000, 5'd10, 32'h0,        32'hffffffff, 0};
    et[4] = "^0@00000000: $10 <= ffffffff#";
    vt[5] = '{1, 14'd16383, 32'habcdef01, 5'd0,  32'h12345678, 32'h00000000, 2};
    et[5] = "^9999@abcdef01: *12345678 <= 00000000#";
    vt[6] = '{0, 14'd100,   32'h00400004, 5'd9,  32'hffffffff, 32'h80000000, 1};
    et[6] = "^100@00400004: $9 <= 80000000#";

    reset = 0; req_valid = 0; req_is_mem = 0; req_time = 0; req_pc = 0;
    req_grf = 0; req_addr = 0; req_data = 0; char_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_char", char, 8'h00);
    chk("rst_valid", char_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1;
    @(negedge clk);

    // Each table frame is issued in the previous frame's frame_done cycle.
    for (int i = 0; i < NV; i++) begin
      send(vt[i].m, vt[i].t, vt[i].pc, vt[i].g, vt[i].ad, vt[i].d);
      run_frame($sformatf("vec%0d", i), et[i], vt[i].mode, 1000, got);
    end

    exp = model(0, 14'd4321, 32'h00001234, 5'd17, 32'h0, 32'hcafef00d);
    send(0, 14'd4321, 32'h00001234, 5'd17, 32'h0, 32'hcafef00d);
    run_frame("abort", exp, 0, 10, got);
    chk_str("abort_prefix", got, exp.substr(0, 9));
    @(negedge clk);
    reset = 0;
    #1;
    chk("abort_valid", char_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", char_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    exp = model(1, 14'd77, 32'h00005000, 5'd0, 32'h0000abcd, 32'h11112222);
    send(1, 14'd77, 32'h00005000, 5'd0, 32'h0000abcd, 32'h11112222);
    run_frame("fresh", exp, 0, 1000, got);

    for (int i = 0; i < 30; i++) begin
      bit          m  = 1'($urandom);
      logic [13:0] t  = (i % 4 == 0) ? 14'($urandom_range(0, 9)) : 14'($urandom);
      logic [31:0] pc = $urandom;
      logic [4:0]  g  = 5'($urandom);
      logic [31:0] ad = $urandom;
      logic [31:0] d  = $urandom;
      int          md = $urandom_range(0, 2);
      exp = model(m, t, pc, g, ad, d);
      send(m, t, pc, g, ad, d);
      run_frame($sformatf("rnd%0d", i), exp, md, 1000, got);
      if (i % 5 == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
